seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with double-buffered BCD value.
// Define LEADING_ZERO_BLANK_EN to also darken leading zero digits 3..1.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter int GUARD    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    output logic [3:0]  bcd_out,
    output logic [3:0]  dig_an_n,
    output logic        frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_PRE  = PW'(SCAN_DIV - 2);
    localparam logic [PW-1:0] P_GEND = PW'(GUARD - 1);

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_GUARD,
        ST_ON
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_active;
    logic [15:0]   r_pend;
    logic          r_pend_full;
    logic [3:0]    r_bcd;
    logic          r_frame_done;
    logic [1:0]    r_idx_d1;
    logic [1:0]    r_idx_d2;
    logic          r_blk_d1;
    logic          r_blk_d2;
    logic          r_on_d1;
    logic          r_on_d2;
    logic [3:0]    r_an_n;

    logic          w_tick;
    logic          w_bnd;
    logic          w_accept;
    logic [3:0]    w_nib;
    logic [3:0]    w_blank;
    logic          w_over;

    assign w_tick   = (r_pcnt == P_LAST);
    assign w_bnd    = w_tick && (r_idx == 2'd3);
    assign w_accept = wr_valid && !r_pend_full;
    assign w_nib    = r_active[{r_idx, 2'b00} +: 4];
    assign w_over   = (w_nib > 4'd9);

    // Per-digit dark flag: out-of-range nibbles, optionally leading zeros
    always_comb begin
        w_blank = '0;
        for (int i = 0; i < 4; i++) begin
            w_blank[i] = (r_active[4*i +: 4] > 4'd9);
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (r_active[15:12] == 4'h0) w_blank[3] = 1'b1;
        if (r_active[15:8] == 8'h00) w_blank[2] = 1'b1;
        if (r_active[15:4] == 12'h000) w_blank[1] = 1'b1;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_BLANK: if (w_bnd && r_pend_full) w_state_nxt = ST_GUARD;
            ST_GUARD: if (r_pcnt == P_GEND) w_state_nxt = ST_ON;
            ST_ON:    if (w_tick) w_state_nxt = ST_GUARD;
            default:  w_state_nxt = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BLANK;
            r_pcnt       <= '0;
            r_idx        <= 2'd0;
            r_active     <= 16'h0000;
            r_pend       <= 16'h0000;
            r_pend_full  <= 1'b0;
            r_bcd        <= 4'h0;
            r_frame_done <= 1'b0;
            r_idx_d1     <= 2'd0;
            r_idx_d2     <= 2'd0;
            r_blk_d1     <= 1'b0;
            r_blk_d2     <= 1'b0;
            r_on_d1      <= 1'b0;
            r_on_d2      <= 1'b0;
            r_an_n       <= 4'hF;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) r_idx <= r_idx + 2'd1;

            if (w_bnd && r_pend_full) begin
                r_active    <= r_pend;
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pend      <= wr_data;
                r_pend_full <= 1'b1;
            end

            r_bcd        <= w_over ? 4'hF : w_nib;
            r_frame_done <= (r_pcnt == P_PRE) && (r_idx == 2'd3);

            // Anode path trails bcd_out by the external decoder's two cycles
            r_idx_d1 <= r_idx;
            r_blk_d1 <= w_blank[r_idx];
            r_on_d1  <= (r_state == ST_ON);
            r_idx_d2 <= r_idx_d1;
            r_blk_d2 <= r_blk_d1;
            r_on_d2  <= r_on_d1;
            r_an_n   <= (r_on_d2 && !r_blk_d2) ?
                        ~(4'b0001 << r_idx_d2) : 4'hF;
        end
    end

    assign wr_ready   = !r_pend_full;
    assign bcd_out    = r_bcd;
    assign dig_an_n   = r_an_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a cycle-count reference model.
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg_scan_ctrl;

    localparam int SD = 16;
    localparam int GD = 4;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic        wr_ready;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_an_n;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .SCAN_DIV(SD),
        .GUARD(GD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .bcd_out(bcd_out),
        .dig_an_n(dig_an_n),
        .frame_done(frame_done)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_pulse = 0;
    bit chk_en = 0;

    // Reference: time since reset, shown value, pending slot, display enabled
    int          m_c;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    bit          m_full;
    bit          m_en;
    bit          m_acc;
    logic [3:0]  h_an [3];
    logic [3:0]  h_bcd;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit dig_dark(input logic [15:0] v, input int i);
        logic [15:0] n;
        n = (v >> (4 * i)) & 16'hF;
        if (n > 9) return 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0) begin
            bit allz;
            allz = 1'b1;
            for (int k = i; k < 4; k++)
                if (((v >> (4 * k)) & 16'hF) != 0) allz = 1'b0;
            if (allz) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_c    = 0;
        m_act  = 16'h0;
        m_pend = 16'h0;
        m_full = 1'b0;
        m_en   = 1'b0;
        h_an   = '{4'hF, 4'hF, 4'hF};
        h_bcd  = 4'h0;
    endtask

    task automatic cyc(input bit r, input bit v, input logic [15:0] d);
        int pc;
        int ix;
        bit bnd;
        logic [15:0] nib;
        logic [3:0] raw_an;
        logic [3:0] raw_bcd;
        rst = r;
        wr_valid = v;
        wr_data = d;
        pc  = m_c % SD;
        ix  = (m_c / SD) % 4;
        bnd = (pc == SD - 1) && (ix == 3);
        if (chk_en) begin
            chk("wr_ready", 16'(wr_ready), 16'(!m_full));
            chk("frame_done", 16'(frame_done), 16'(bnd));
            chk("bcd_out", 16'(bcd_out), 16'(h_bcd));
            chk("dig_an_n", 16'(dig_an_n), 16'(h_an[2]));
        end
        if (frame_done === 1'b1) n_pulse++;
        m_acc = 1'b0;
        if (r) begin
            model_reset();
        end else begin
            nib = (m_act >> (4 * ix)) & 16'hF;
            raw_bcd = (nib > 9) ? 4'hF : nib[3:0];
            raw_an = (m_en && pc >= GD && !dig_dark(m_act, ix)) ?
                     ~(4'b0001 << ix) : 4'hF;
            h_an[2] = h_an[1];
            h_an[1] = h_an[0];
            h_an[0] = raw_an;
            h_bcd = raw_bcd;
            if (bnd && m_full) begin
                m_act  = m_pend;
                m_full = 1'b0;
                m_en   = 1'b1;
            end else if (v && !m_full) begin
                m_pend = d;
                m_full = 1'b1;
                m_acc  = 1'b1;
            end
            m_c++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0);
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        int p;
        v = 16'h0;
        for (int i = 0; i < 4; i++) begin
            p = $urandom_range(0, 99);
            if (p < 40) v = v;
            else if (p < 85) v = v | (16'($urandom_range(1, 9)) << (4 * i));
            else v = v | (16'($urandom_range(10, 15)) << (4 * i));
        end
        return v;
    endfunction

    initial begin
        model_reset();
        cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 16'h0);
        chk_en = 1;

        cyc(1'b0, 1'b1, 16'h1234);
        idle(200);

        cyc(1'b0, 1'b1, 16'h5678);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b1, 16'h9999);
            if (m_acc) break;
        end
        idle(150);

        for (int i = 0; i < 200; i++) begin
            if ((m_c % FR) == FR - 1 && !m_full) break;
            cyc(1'b0, 1'b0, 16'h0);
        end
        cyc(1'b0, 1'b1, 16'h4321);
        idle(150);

        cyc(1'b0, 1'b1, 16'h00A7);
        idle(200);

        cyc(1'b0, 1'b1, 16'h0000);
        idle(150);

        idle(23);
        cyc(1'b1, 1'b0, 16'h0);
        n_pulse = 0;
        idle(FR * 10);
        chk("frame_cnt", 16'(n_pulse), 16'd10);

        for (int i = 0; i < 2500; i++) begin
            cyc($urandom_range(0, 599) == 0,
                $urandom_range(0, 7) == 0,
                rand_val());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
